qracc_output_stage: RTL and testbench
=====================================

QRACC_OUTPUT_STAGE -- requirements
Module: qracc_output_stage

Interface
REQ-001 SHALL have parameter outputElements, default 32, columns delivered per seq_acc result.
REQ-002 SHALL have parameter accumulatorBits, default 7, width of each signed seq_acc output.
REQ-003 SHALL have parameter psumBits, default 16, signed partial-sum width; must be >= accumulatorBits+4.
REQ-004 SHALL have parameters outBits (default 8, signed result width), outLanes (default 8, results per beat; outputElements divisible by outLanes), and scaleBits (default 8, unsigned multiplier width).
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-006 SHALL have port nrst, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port in_valid_i, input, 1, seq_acc valid_o pulse.
REQ-008 SHALL have port in_data_i, input, outputElements x accumulatorBits, seq_acc mac_data_o, two's complement.
REQ-009 SHALL have config inputs: n_tiles_i (4b, row tiles per output; 0 is treated as 1), scale_i (scaleBits), shift_i (4b), relu_en_i (1b).
REQ-010 SHALL have port clear_i, input, 1, synchronous abort and error clear.
REQ-011 SHALL have port busy_o, output, 1, high when new in_valid_i cannot be accepted.
REQ-012 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_data_o (output, outLanes x outBits), and out_last_o (output, 1, final beat).
REQ-013 SHALL have port err_overflow_o, output, 1, sticky flag for a dropped in_valid_i.

Function
REQ-014 SHALL implement FSM states ACCUM, REQUANT, DRAIN.
REQ-015 ACCUM: on in_valid_i, when tile_cnt==0, each psum SHALL be loaded with the sign-extended input; otherwise the sign-extended input SHALL be added, wrapping at psumBits.
REQ-016 Config (n_tiles, scale, shift, relu_en) SHALL be latched on the tile_cnt==0 beat and held until DRAIN completes.
REQ-017 On the beat where tile_cnt==latched n_tiles-1, the block SHALL clear tile_cnt and enter REQUANT next cycle; otherwise it SHALL increment tile_cnt.
REQ-018 REQUANT SHALL last exactly one cycle, registering all outputElements results, then enter DRAIN.
REQ-019 Per element, the result SHALL be psum*scale (signed x unsigned, full width), plus 2^(shift-1) when shift>0, then arithmetic shift right by shift.
REQ-020 The result SHALL then saturate to [-2^(outBits-1), 2^(outBits-1)-1], and negative values SHALL be forced to 0 when relu_en is set.
REQ-021 DRAIN SHALL emit outputElements/outLanes beats, with beat b carrying elements b*outLanes..b*outLanes+outLanes-1 and lane 0 being the lowest element.
REQ-022 During DRAIN, out_valid_o SHALL be high; the beat SHALL advance only on out_valid_o&&out_ready_i; out_data_o and out_last_o SHALL hold stable while stalled.
REQ-023 out_last_o SHALL be high only on the final beat; after that beat's handshake the FSM SHALL return to ACCUM with out_valid_o low in the next cycle.
REQ-024 busy_o SHALL equal (state!=ACCUM).
REQ-025 An in_valid_i while busy_o SHALL be dropped, leave psums and counters unchanged, and set err_overflow_o.
REQ-026 clear_i SHALL return the FSM to ACCUM, zero tile_cnt, zero the beat counter, deassert out_valid_o, and clear err_overflow_o; it SHALL take priority over every other event that cycle.
REQ-027 An in_valid_i in the same cycle as clear_i SHALL be dropped without setting the error.
REQ-028 Latency SHALL be: last-tile in_valid_i at cycle t gives REQUANT at t+1 and first out_valid_o at t+2.

Reset
REQ-029 nrst low SHALL asynchronously force state=ACCUM, tile_cnt=0, beat=0, psums=0, result buffer=0, and latched config=0.
REQ-030 During reset the outputs SHALL be out_valid_o=0, out_last_o=0, out_data_o=0, busy_o=0, err_overflow_o=0.
REQ-031 Reset asserted mid-DRAIN SHALL abandon the pending beats; no beat SHALL be emitted after reset release until a new tile sequence completes.

Structure
REQ-032 The state enum and a qracc_requant_cfg_t struct (n_tiles, scale, shift, relu_en) SHALL reside in qracc_pkg.
REQ-033 One sub-module, qracc_requant_lane, SHALL perform the combinational multiply/round/shift/saturate/ReLU of REQ-019/020 and SHALL be instantiated outputElements times.

Verification
REQ-034 n_tiles=1, scale=1, shift=0, relu=0, all inputs 5 -> 4 beats, every lane 5, out_last_o on beat 3, first valid 2 cycles after input.
REQ-035 n_tiles=3, inputs 50,50,50, scale=1, shift=0 -> psum 150, output saturates to 127; inputs -50 x3 -> -128.
REQ-036 n_tiles=1, scale=3, shift=2, input 5 -> 4; input -5 -> -4; input -5 with relu=1 -> 0.
REQ-037 out_ready_i low for 3 cycles on beat 1 -> beat-1 data and out_last_o=0 held stable, beats 2-3 follow in order.
REQ-038 in_valid_i pulse during DRAIN -> err_overflow_o=1, drained values unchanged; clear_i -> err_overflow_o=0, FSM in ACCUM.
REQ-039 nrst asserted on beat 2 -> outputs zero immediately; after release, no out_valid_o until a new n_tiles sequence completes.

Source files
------------

// File: rtl/qracc_pkg.sv
// rtl/qracc_pkg.sv - shared state encoding and latched requant config for the QRACC output stage
package qracc_pkg;

  // Upper bound on scaleBits; the latched scale field is this wide.
  localparam int QRACC_MAX_SCALE_BITS = 16;

  typedef enum logic [1:0] {
    ST_ACCUM   = 2'd0,
    ST_REQUANT = 2'd1,
    ST_DRAIN   = 2'd2
  } qracc_state_e;

  typedef struct packed {
    logic [3:0]                      n_tiles;
    logic [QRACC_MAX_SCALE_BITS-1:0] scale;
    logic [3:0]                      shift;
    logic                            relu_en;
  } qracc_requant_cfg_t;

  function automatic logic [3:0] qracc_norm_tiles(input logic [3:0] n);
    return (n == 4'd0) ? 4'd1 : n;
  endfunction

endpackage

// File: rtl/qracc_output_stage_if.sv
// rtl/qracc_output_stage_if.sv - seq_acc input beat and requantised output stream bundle
interface qracc_output_stage_if #(
  parameter int outputElements  = 32,
  parameter int accumulatorBits = 7,
  parameter int outLanes        = 8,
  parameter int outBits         = 8
);
  logic                                           in_valid_i;
  logic [outputElements-1:0][accumulatorBits-1:0] in_data_i;
  logic                                           out_valid_o;
  logic                                           out_ready_i;
  logic [outLanes-1:0][outBits-1:0]               out_data_o;
  logic                                           out_last_o;

  modport master (
    output in_valid_i, in_data_i, out_ready_i,
    input  out_valid_o, out_data_o, out_last_o
  );

  modport slave (
    input  in_valid_i, in_data_i, out_ready_i,
    output out_valid_o, out_data_o, out_last_o
  );
endinterface

// File: rtl/qracc_requant_lane.sv
// rtl/qracc_requant_lane.sv - one element: psum*scale, round, arithmetic shift, saturate, optional ReLU
module qracc_requant_lane #(
  parameter int psumBits  = 16,
  parameter int scaleBits = 8,
  parameter int outBits   = 8
) (
  input  logic signed [psumBits-1:0] psum_i,
  input  logic        [scaleBits-1:0] scale_i,
  input  logic        [3:0]           shift_i,
  input  logic                        relu_en_i,
  output logic        [outBits-1:0]   result_o
);

  // Two spare bits: one for the unsigned scale's sign, one for the rounding add.
  localparam int ProdBits = psumBits + scaleBits + 2;
  localparam logic signed [ProdBits-1:0] SatMax = ProdBits'((64'sd1 <<< (outBits - 1)) - 64'sd1);
  localparam logic signed [ProdBits-1:0] SatMin = ProdBits'(-(64'sd1 <<< (outBits - 1)));

  logic signed [ProdBits-1:0] psum_ext;
  logic signed [ProdBits-1:0] scale_ext;
  logic signed [ProdBits-1:0] prod;
  logic signed [ProdBits-1:0] rnd;
  logic signed [ProdBits-1:0] shifted;
  logic signed [ProdBits-1:0] sat;

  always_comb begin
    psum_ext  = ProdBits'(psum_i);
    scale_ext = $signed(ProdBits'(scale_i));
    prod      = psum_ext * scale_ext;
    rnd       = '0;
    if (shift_i != 4'd0) begin
      rnd = ProdBits'(1) <<< (shift_i - 4'd1);
    end
    shifted = (prod + rnd) >>> shift_i;
    if (shifted > SatMax) begin
      sat = SatMax;
    end else if (shifted < SatMin) begin
      sat = SatMin;
    end else begin
      sat = shifted;
    end
    result_o = (relu_en_i && sat[ProdBits-1]) ? '0 : outBits'(sat);
  end

endmodule

// File: rtl/qracc_output_stage.sv
// rtl/qracc_output_stage.sv - accumulate seq_acc row tiles, requantise, drain as outLanes-wide beats
module qracc_output_stage
  import qracc_pkg::*;
#(
  parameter int outputElements  = 32,
  parameter int accumulatorBits = 7,
  parameter int psumBits        = 16,
  parameter int outBits         = 8,
  parameter int outLanes        = 8,
  parameter int scaleBits       = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  qracc_output_stage_if.slave   io,
  input  logic [3:0]            n_tiles_i,
  input  logic [scaleBits-1:0]  scale_i,
  input  logic [3:0]            shift_i,
  input  logic                  relu_en_i,
  input  logic                  clear_i,
  output logic                  busy_o,
  output logic                  err_overflow_o
);

  localparam int NumBeats = outputElements / outLanes;
  localparam int BeatBits = (NumBeats > 1) ? $clog2(NumBeats) : 1;
  localparam logic [BeatBits-1:0] LastBeat = BeatBits'(NumBeats - 1);

  qracc_state_e       state_q, state_d;
  logic [3:0]         tile_cnt_q, tile_cnt_d;
  logic [BeatBits-1:0] beat_q, beat_d;
  qracc_requant_cfg_t cfg_q, cfg_d;
  logic               err_q, err_d;
  logic [3:0]         eff_tiles;

  logic [outputElements-1:0][psumBits-1:0]        psum_q, psum_d;
  logic [NumBeats-1:0][outLanes-1:0][outBits-1:0] res_q, res_d, lane_res;

  for (genvar e = 0; e < outputElements; e++) begin : g_lane
    qracc_requant_lane #(
      .psumBits  (psumBits),
      .scaleBits (scaleBits),
      .outBits   (outBits)
    ) u_lane (
      .psum_i    ($signed(psum_q[e])),
      .scale_i   (cfg_q.scale[scaleBits-1:0]),
      .shift_i   (cfg_q.shift),
      .relu_en_i (cfg_q.relu_en),
      .result_o  (lane_res[e / outLanes][e % outLanes])
    );
  end

  always_comb begin
    state_d    = state_q;
    tile_cnt_d = tile_cnt_q;
    beat_d     = beat_q;
    cfg_d      = cfg_q;
    err_d      = err_q;
    psum_d     = psum_q;
    res_d      = res_q;
    // The first tile compares against the incoming n_tiles, later tiles against the latched copy.
    eff_tiles  = qracc_norm_tiles((tile_cnt_q == 4'd0) ? n_tiles_i : cfg_q.n_tiles);

    unique case (state_q)
      ST_ACCUM: begin
        if (io.in_valid_i) begin
          if (tile_cnt_q == 4'd0) begin
            cfg_d.n_tiles = qracc_norm_tiles(n_tiles_i);
            cfg_d.scale   = QRACC_MAX_SCALE_BITS'(scale_i);
            cfg_d.shift   = shift_i;
            cfg_d.relu_en = relu_en_i;
          end
          for (int e = 0; e < outputElements; e++) begin
            if (tile_cnt_q == 4'd0) begin
              psum_d[e] = psumBits'($signed(io.in_data_i[e]));
            end else begin
              psum_d[e] = psum_q[e] + psumBits'($signed(io.in_data_i[e]));
            end
          end
          if (tile_cnt_q == eff_tiles - 4'd1) begin
            tile_cnt_d = 4'd0;
            state_d    = ST_REQUANT;
          end else begin
            tile_cnt_d = tile_cnt_q + 4'd1;
          end
        end
      end
      ST_REQUANT: begin
        res_d   = lane_res;
        beat_d  = '0;
        state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (io.out_ready_i) begin
          if (beat_q == LastBeat) begin
            beat_d  = '0;
            state_d = ST_ACCUM;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase

    if (io.in_valid_i && (state_q != ST_ACCUM)) begin
      err_d = 1'b1;
    end

    // Abort wins over everything, including a coincident input beat.
    if (clear_i) begin
      state_d    = ST_ACCUM;
      tile_cnt_d = 4'd0;
      beat_d     = '0;
      err_d      = 1'b0;
      cfg_d      = cfg_q;
      psum_d     = psum_q;
      res_d      = res_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= ST_ACCUM;
      tile_cnt_q <= 4'd0;
      beat_q     <= '0;
      cfg_q      <= '0;
      err_q      <= 1'b0;
      psum_q     <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      tile_cnt_q <= tile_cnt_d;
      beat_q     <= beat_d;
      cfg_q      <= cfg_d;
      err_q      <= err_d;
      psum_q     <= psum_d;
      res_q      <= res_d;
    end
  end

  assign busy_o          = (state_q != ST_ACCUM);
  assign err_overflow_o  = err_q;
  assign io.out_valid_o  = (state_q == ST_DRAIN);
  assign io.out_last_o   = (state_q == ST_DRAIN) && (beat_q == LastBeat);
  assign io.out_data_o   = (state_q == ST_DRAIN) ? res_q[beat_q] : '0;

endmodule

// File: tb/tb_qracc_output_stage.sv
// tb/tb_qracc_output_stage.sv - scoreboard bench for qracc_output_stage
module tb_qracc_output_stage;
  import qracc_pkg::*;

  localparam int OE = 32;
  localparam int AB = 7;
  localparam int PB = 16;
  localparam int OB = 8;
  localparam int OL = 8;
  localparam int SB = 8;
  localparam int NB = OE / OL;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          idx;
  } beat_t;

  logic          clk;
  logic          nrst;
  logic [3:0]    n_tiles;
  logic [SB-1:0] scale;
  logic [3:0]    shift;
  logic          relu_en;
  logic          clear;
  logic          busy;
  logic          err;

  qracc_output_stage_if #(.outputElements(OE), .accumulatorBits(AB), .outLanes(OL), .outBits(OB)) io ();

  qracc_output_stage #(
    .outputElements(OE), .accumulatorBits(AB), .psumBits(PB),
    .outBits(OB), .outLanes(OL), .scaleBits(SB)
  ) dut (
    .clk(clk), .nrst(nrst), .io(io),
    .n_tiles_i(n_tiles), .scale_i(scale), .shift_i(shift), .relu_en_i(relu_en),
    .clear_i(clear), .busy_o(busy), .err_overflow_o(err)
  );

  int    n_checks = 0;
  int    n_fail = 0;
  beat_t exp_q[$];
  bit    stall_en = 0;
  int    stall_cnt = 0;
  bit    chk_after_last = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_requant(input int psum, input int sc, input int sh, input bit relu);
    longint p;
    p = longint'(psum) * longint'(sc);
    if (sh > 0) p = p + (longint'(1) << (sh - 1));
    p = p >>> sh;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    if (relu && p < 0) p = 0;
    return int'(p);
  endfunction

  // Scoreboard monitor: compare every presented beat, pop on handshake.
  always @(negedge clk) begin
    if (nrst) begin
      if (chk_after_last) begin
        check_eq("valid_after_last", 64'(io.out_valid_o), 64'd0);
        chk_after_last = 0;
      end
      if (io.out_valid_o) begin
        check_eq("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          check_eq("beat_data", io.out_data_o, exp_q[0].data);
          check_eq("beat_last", 64'(io.out_last_o), 64'(exp_q[0].last));
          if (io.out_ready_i) begin
            if (exp_q[0].last) chk_after_last = 1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    io.out_ready_i = 1;
    forever begin
      @(posedge clk); #1;
      if (stall_en && io.out_valid_o && exp_q.size() != 0 && exp_q[0].idx == 1 && stall_cnt < 3) begin
        io.out_ready_i = 0;
        stall_cnt++;
      end else begin
        io.out_ready_i = 1;
      end
    end
  end

  task automatic run_case(input int ntiles, input int b0, input int b1, input int b2, input bit ramp,
                          input int sc, input int sh, input bit relu);
    int    eff;
    int    bases[3];
    int    psum[OE];
    int    v;
    beat_t bt;
    eff = (ntiles == 0) ? 1 : ntiles;
    bases = '{b0, b1, b2};
    for (int e = 0; e < OE; e++) psum[e] = 0;
    for (int t = 0; t < eff; t++)
      for (int e = 0; e < OE; e++) begin
        v = bases[t] + (ramp ? e - 16 : 0);
        psum[e] = int'(shortint'(psum[e] + v));
      end
    for (int b = 0; b < NB; b++) begin
      bt.data = '0;
      for (int l = 0; l < OL; l++)
        bt.data[l*OB +: OB] = OB'(model_requant(psum[b*OL + l], sc, sh, relu));
      bt.last = (b == NB - 1);
      bt.idx  = b;
      exp_q.push_back(bt);
    end
    for (int t = 0; t < eff; t++) begin
      @(posedge clk); #1;
      io.in_valid_i = 1;
      for (int e = 0; e < OE; e++) io.in_data_i[e] = AB'(bases[t] + (ramp ? e - 16 : 0));
      if (t == 0) begin
        n_tiles = 4'(ntiles); scale = SB'(sc); shift = 4'(sh); relu_en = relu;
      end else begin
        n_tiles = 4'($urandom_range(0, 15)); scale = SB'($urandom_range(0, 255));
        shift = 4'($urandom_range(0, 15)); relu_en = 1'($urandom_range(0, 1));
      end
    end
    @(posedge clk); #1;
    io.in_valid_i = 0;
    @(negedge clk);
    check_eq("lat_requant_valid", 64'(io.out_valid_o), 64'd0);
    check_eq("lat_requant_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check_eq("lat_first_valid", 64'(io.out_valid_o), 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check_eq("drain_done", 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    check_eq("idle_after_drain", 64'(io.out_valid_o), 64'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_valid"}, 64'(io.out_valid_o), 64'd0);
    check_eq({tag, "_last"}, 64'(io.out_last_o), 64'd0);
    check_eq({tag, "_data"}, io.out_data_o, 64'd0);
    check_eq({tag, "_busy"}, 64'(busy), 64'd0);
    check_eq({tag, "_err"}, 64'(err), 64'd0);
  endtask

  initial begin
    int nvalid;
    nrst = 0; clear = 0; n_tiles = 0; scale = 0; shift = 0; relu_en = 0;
    io.in_valid_i = 0; io.in_data_i = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    nrst = 1;

    run_case(1, 5, 0, 0, 0, 1, 0, 0);
    wait_drain();
    run_case(3, 50, 50, 50, 0, 1, 0, 0);
    wait_drain();
    run_case(3, -50, -50, -50, 0, 1, 0, 0);
    wait_drain();
    run_case(1, 5, 0, 0, 0, 3, 2, 0);
    wait_drain();
    run_case(1, -5, 0, 0, 0, 3, 2, 0);
    wait_drain();
    run_case(1, -5, 0, 0, 0, 3, 2, 1);
    wait_drain();
    run_case(0, 7, 0, 0, 1, 2, 1, 0);
    wait_drain();
    run_case(2, 3, -4, 0, 1, 5, 3, 1);
    wait_drain();
    run_case(2, 20, 13, 0, 1, 200, 7, 0);
    wait_drain();

    stall_en = 1; stall_cnt = 0;
    run_case(1, 9, 0, 0, 1, 1, 0, 0);
    wait_drain();
    check_eq("stall_cycles", 64'(stall_cnt), 64'd3);
    stall_en = 0;

    run_case(1, 10, 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1;
    io.in_valid_i = 1;
    for (int e = 0; e < OE; e++) io.in_data_i[e] = AB'(33);
    @(posedge clk); #1;
    io.in_valid_i = 0;
    wait_drain();
    check_eq("err_set", 64'(err), 64'd1);
    @(posedge clk); #1; clear = 1;
    @(posedge clk); #1; clear = 0;
    @(negedge clk);
    check_eq("err_cleared", 64'(err), 64'd0);
    check_eq("clear_busy", 64'(busy), 64'd0);

    @(posedge clk); #1;
    clear = 1; io.in_valid_i = 1; n_tiles = 4'd2;
    for (int e = 0; e < OE; e++) io.in_data_i[e] = AB'(40);
    @(posedge clk); #1;
    clear = 0; io.in_valid_i = 0;
    @(negedge clk);
    check_eq("clear_valid_err", 64'(err), 64'd0);
    run_case(1, -3, 0, 0, 1, 4, 1, 0);
    wait_drain();

    run_case(1, 5, 0, 0, 0, 1, 0, 0);
    @(posedge clk); @(posedge clk); #1;
    nrst = 0;
    #1;
    check_outputs_zero("mid_drain_rst");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 nrst = 1;
    nvalid = 0;
    repeat (10) begin
      @(negedge clk);
      if (io.out_valid_o) nvalid++;
    end
    check_eq("no_valid_after_rst", 64'(nvalid), 64'd0);
    run_case(2, 6, -2, 0, 0, 1, 0, 0);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
